// File: rtl/ysyx_24110015_sram_axi_if.sv
// AXI4-Lite style bus between a master and the SRAM slave: AR/R read channels, AW/W/B write channels.
// The master modport drives valids, addresses and data; the slave modport drives readies and responses.
interface ysyx_24110015_sram_axi_if;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arsize, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awsize, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arsize, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awsize, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/ysyx_24110015_sram_axi.sv
// Word-addressed SRAM behind an AXI-Lite slave; independent read and write FSMs, one transaction each.
// Response appears LAT+1 cycles after the (last) address/data handshake and is held until ready.
module ysyx_24110015_sram_axi #(
    parameter logic [31:0] BASE  = 32'h0f000000,
    parameter int          DEPTH = 256,
    parameter int          LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_24110015_sram_axi_if.slave  bus
);
    localparam int          IW     = $clog2(DEPTH);
    localparam logic [31:0] SPAN   = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_LD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    // Addresses below BASE wrap to huge offsets, so one unsigned compare covers both bounds.
    function automatic logic addr_hit(input logic [31:0] a);
        return (a - BASE) < SPAN;
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[IW+1:2];
    endfunction

    logic [31:0] mem_q [DEPTH];

    r_state_e    r_state_q, r_state_d;
    logic [31:0] raddr_q,   raddr_d;
    logic [3:0]  rcnt_q,    rcnt_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;
    logic        r_load;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] awaddr_q,  awaddr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic        aw_got_q,  aw_got_d;
    logic        w_got_q,   w_got_d;
    logic [3:0]  wcnt_q,    wcnt_d;
    logic [1:0]  bresp_q,   bresp_d;
    logic        w_commit;

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rcnt_d    = rcnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_load    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    raddr_d = bus.araddr;
                    if (LAT == 0) begin
                        r_state_d = R_RESP;
                        r_load    = 1'b1;
                    end else begin
                        r_state_d = R_WAIT;
                        rcnt_d    = CNT_LD;
                    end
                end
            end
            R_WAIT: begin
                if (rcnt_q == 4'd0) begin
                    r_state_d = R_RESP;
                    r_load    = 1'b1;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (bus.rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        // mem_q still holds pre-commit data here, so a same-edge write is not visible to this read.
        if (r_load) begin
            rdata_d = addr_hit(raddr_d) ? mem_q[word_idx(raddr_d)] : 32'd0;
            rresp_d = addr_hit(raddr_d) ? 2'b00 : 2'b10;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        wcnt_d    = wcnt_q;
        bresp_d   = bresp_q;
        w_commit  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (!aw_got_q && bus.awvalid) begin
                    awaddr_d = bus.awaddr;
                    aw_got_d = 1'b1;
                end
                if (!w_got_q && bus.wvalid) begin
                    wdata_d = bus.wdata;
                    wstrb_d = bus.wstrb;
                    w_got_d = 1'b1;
                end
                if (aw_got_d && w_got_d) begin
                    if (LAT == 0) begin
                        w_state_d = W_RESP;
                        w_commit  = 1'b1;
                    end else begin
                        w_state_d = W_WAIT;
                        wcnt_d    = CNT_LD;
                    end
                end
            end
            W_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    w_state_d = W_RESP;
                    w_commit  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_d = W_IDLE;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (w_commit) bresp_d = addr_hit(awaddr_d) ? 2'b00 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            raddr_q   <= 32'd0;
            rcnt_q    <= 4'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            w_state_q <= W_IDLE;
            awaddr_q  <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            wcnt_q    <= 4'd0;
            bresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rcnt_q    <= rcnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            wcnt_q    <= wcnt_d;
            bresp_q   <= bresp_d;
        end
    end

    // Storage is deliberately not reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (w_commit && !rst && addr_hit(awaddr_d)) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_d[i]) mem_q[word_idx(awaddr_d)][8*i +: 8] <= wdata_d[8*i +: 8];
            end
        end
    end

    assign bus.arready = (r_state_q == R_IDLE);
    assign bus.rvalid  = (r_state_q == R_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.awready = (w_state_q == W_IDLE) && !aw_got_q;
    assign bus.wready  = (w_state_q == W_IDLE) && !w_got_q;
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_ysyx_24110015_sram_axi.sv
// Directed + randomized bench for the AXI-Lite SRAM, checked against a word-array reference model.
module tb_ysyx_24110015_sram_axi;
    localparam logic [31:0] BASE  = 32'h0f000000;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] ref_mem [DEPTH];

    ysyx_24110015_sram_axi_if bus();

    ysyx_24110015_sram_axi #(.BASE(BASE), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_start, input int w_start, input int b_hold);
        logic [1:0]  exp_resp;
        logic [1:0]  resp0;
        logic [31:0] mask;
        bit          aw_done, w_done, aw_fire, w_fire;
        int          cyc, k;
        exp_resp = in_rng(addr) ? 2'b00 : 2'b10;
        aw_done  = 1'b0;
        w_done   = 1'b0;
        cyc      = 0;
        bus.bready = 1'b0;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge clk);
            bus.awaddr  = addr;
            bus.awsize  = 3'd2;
            bus.wdata   = data;
            bus.wstrb   = strb;
            bus.awvalid = !aw_done && (cyc >= aw_start);
            bus.wvalid  = !w_done && (cyc >= w_start);
            if (w_done)  chk("wready_low_after_w", 32'(bus.wready), 32'd0);
            if (aw_done) chk("awready_low_after_aw", 32'(bus.awready), 32'd0);
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(posedge clk);
            aw_done = aw_done || aw_fire;
            w_done  = w_done || w_fire;
            cyc++;
        end
        chk("write_handshakes", 32'(aw_done && w_done), 32'd1);
        k = 0;
        do begin
            @(negedge clk);
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            k++;
        end while (!bus.bvalid && k < 20);
        chk("b_latency", 32'(k), 32'(LAT + 1));
        resp0 = bus.bresp;
        chk("bresp", 32'(resp0), 32'(exp_resp));
        for (int i = 0; i < b_hold; i++) begin
            @(negedge clk);
            chk("bvalid_held", 32'(bus.bvalid), 32'd1);
            chk("bresp_held", 32'(bus.bresp), 32'(resp0));
        end
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        chk("bvalid_drop", 32'(bus.bvalid), 32'd0);
        if (in_rng(addr)) begin
            mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            ref_mem[idx_of(addr)] = (ref_mem[idx_of(addr)] & ~mask) | (data & mask);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_hold);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [31:0] d0;
        int          cyc, k;
        exp_data = in_rng(addr) ? ref_mem[idx_of(addr)] : 32'd0;
        exp_resp = in_rng(addr) ? 2'b00 : 2'b10;
        cyc = 0;
        bus.rready = 1'b0;
        @(negedge clk);
        bus.araddr  = addr;
        bus.arsize  = 3'd2;
        bus.arvalid = 1'b1;
        while (!bus.arready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("ar_ready", 32'(bus.arready), 32'd1);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            bus.arvalid = 1'b0;
            k++;
        end while (!bus.rvalid && k < 20);
        chk("r_latency", 32'(k), 32'(LAT + 1));
        d0 = bus.rdata;
        chk("rdata", d0, exp_data);
        chk("rresp", 32'(bus.rresp), 32'(exp_resp));
        for (int i = 0; i < r_hold; i++) begin
            @(negedge clk);
            chk("rvalid_held", 32'(bus.rvalid), 32'd1);
            chk("rdata_held", bus.rdata, d0);
        end
        bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
        chk("rvalid_drop", 32'(bus.rvalid), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, d, old3;
        logic [3:0]  s;

        bus.araddr = '0; bus.arsize = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awsize = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_arready", 32'(bus.arready), 32'd1);
        chk("rst_awready", 32'(bus.awready), 32'd1);
        chk("rst_wready",  32'(bus.wready),  32'd1);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
        chk("rst_rdata",   bus.rdata,        32'd0);
        chk("rst_rresp",   32'(bus.rresp),   32'd0);
        chk("rst_bresp",   32'(bus.bresp),   32'd0);

        // Give every word a known value so the model is fully defined.
        for (int i = 0; i < DEPTH; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hf, 0, 0, 0);

        do_write(32'h0f000004, 32'hdeadbeef, 4'hf, 0, 0, 0);
        do_read(32'h0f000004, 0);
        chk("basic_rdata", bus.rdata, 32'hdeadbeef);

        do_write(32'h0f000004, 32'h00aa0000, 4'b0100, 0, 0, 0);
        do_read(32'h0f000006, 1);
        chk("byte_lane_rdata", bus.rdata, 32'hdeaabeef);

        // W leads AW by three cycles; B held off for four cycles.
        do_write(BASE + 32'h20, 32'h13572468, 4'hf, 3, 0, 4);
        do_read(BASE + 32'h20, 0);
        chk("w_first_rdata", bus.rdata, 32'h13572468);
        do_write(BASE + 32'h24, 32'h0badf00d, 4'b0011, 0, 2, 1);
        do_read(BASE + 32'h24, 0);

        do_read(32'h10000000, 2);
        chk("oor_read_resp", 32'(bus.rresp), 32'h2);
        do_write(32'h0effffff, 32'hffffffff, 4'hf, 0, 0, 2);
        chk("oor_write_resp", 32'(bus.bresp), 32'h2);
        do_read(BASE, 0);
        do_write(BASE + 32'(4 * DEPTH), 32'h12345678, 4'hf, 1, 0, 0);
        do_read(BASE + 32'(4 * DEPTH) - 32'd4, 0);

        // Reset while both paths sit in their wait state.
        @(negedge clk);
        bus.araddr = BASE + 32'd20; bus.arvalid = 1'b1; bus.rready = 1'b1;
        bus.awaddr = BASE + 32'd20; bus.awvalid = 1'b1; bus.bready = 1'b1;
        bus.wdata  = ~ref_mem[5];   bus.wstrb   = 4'hf; bus.wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("wait_arready", 32'(bus.arready), 32'd0);
        chk("wait_awready", 32'(bus.awready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rvalid",  32'(bus.rvalid),  32'd0);
        chk("abort_bvalid",  32'(bus.bvalid),  32'd0);
        chk("abort_arready", 32'(bus.arready), 32'd1);
        chk("abort_awready", 32'(bus.awready), 32'd1);
        chk("abort_wready",  32'(bus.wready),  32'd1);
        chk("abort_rdata",   bus.rdata,        32'd0);
        chk("abort_bresp",   32'(bus.bresp),   32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rvalid", 32'(bus.rvalid), 32'd0);
            chk("abort_no_bvalid", 32'(bus.bvalid), 32'd0);
        end
        bus.rready = 1'b0; bus.bready = 1'b0;
        do_read(BASE + 32'd20, 0);

        // Read sampling and write commit of word 3 on the same edge.
        old3 = ref_mem[3];
        fork
            do_read(BASE + 32'd12, 0);
            do_write(BASE + 32'd12, ~old3, 4'hf, 0, 0, 0);
        join
        chk("same_edge_old", bus.rdata, old3);
        do_read(BASE + 32'd12, 0);
        chk("same_edge_new", bus.rdata, ~old3);

        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) == 0) ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255))
                                            : BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            b = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0: do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                1: do_read(a, $urandom_range(0, 3));
                default: fork
                    do_read(b, $urandom_range(0, 2));
                    do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
                join
            endcase
        end
        for (int i = 0; i < 8; i++) do_read(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_24110015_sram_axi.md
YSYX_24110015_SRAM_AXI -- requirements
Module: ysyx_24110015_sram_axi

Interface
REQ-001 Parameter BASE, default 32'h0f000000: byte address of word 0.
REQ-002 Parameter DEPTH, default 256: number of 32-bit storage words (power of two, 2..4096).
REQ-003 Parameter LAT, default 2: wait cycles between address/data acceptance and response (0..15).
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port araddr  input  32  read byte address.
REQ-007 Port arsize  input  3  read size; accepted but ignored (full word always returned).
REQ-008 Port arvalid  input  1 / arready  output  1  read address handshake.
REQ-009 Port rdata  output  32 / rresp  output  2 / rvalid  output  1 / rready  input  1  read data channel.
REQ-010 Port awaddr  input  32 / awsize  input  3 / awvalid  input  1 / awready  output  1  write address channel; awsize ignored.
REQ-011 Port wdata  input  32 / wstrb  input  4 / wvalid  input  1 / wready  output  1  write data channel.
REQ-012 Port bresp  output  2 / bvalid  output  1 / bready  input  1  write response channel.

Function
REQ-013 Read and write paths shall be independent FSMs; each holds at most one outstanding transaction.
REQ-014 Read FSM states R_IDLE, R_WAIT, R_RESP; arready = 1 only in R_IDLE.
REQ-015 R_IDLE: arvalid&arready latches araddr; goes to R_WAIT (LAT>0) or R_RESP (LAT=0) next cycle.
REQ-016 R_WAIT: counter loads LAT-1 on entry, decrements each cycle; at zero goes to R_RESP.
REQ-017 Entering R_RESP: rdata/rresp registered from memory; held stable, rvalid=1, until rvalid&rready; then R_IDLE.
REQ-018 Address decode: in-range iff BASE <= addr < BASE+4*DEPTH; word index = (addr-BASE)[..:2]; addr[1:0] ignored.
REQ-019 Out-of-range read: rdata=0, rresp=2'b10 (SLVERR); in-range: rresp=2'b00.
REQ-020 Write FSM states W_IDLE, W_WAIT, W_RESP; in W_IDLE awready=1 until AW captured, wready=1 until W captured; AW and W accepted in any order or same cycle.
REQ-021 Once both AW and W captured, next cycle enter W_WAIT (LAT>0) or W_RESP (LAT=0); awready=wready=0 outside W_IDLE.
REQ-022 Memory commit on W_RESP entry: byte lane i written iff wstrb[i]; wstrb=0 writes nothing, bresp=OKAY.
REQ-023 Out-of-range write: no memory change, bresp=2'b10; else bresp=2'b00.
REQ-024 W_RESP: bvalid=1 until bvalid&bready, then W_IDLE.
REQ-025 Read sampling and write commit to same word in same cycle: read returns pre-write data.
REQ-026 rvalid/bvalid shall not drop and rdata/rresp/bresp shall not change while awaiting ready.
REQ-027 Latency: with LAT=L and ready held high, rvalid asserts L+1 cycles after the ar handshake cycle; bvalid likewise after the later of the aw/w handshakes.

Reset
REQ-028 rst=1 at a clock edge: both FSMs to IDLE, counters 0, captured-AW/W flags cleared, any in-flight transaction dropped without response.
REQ-029 Values after reset: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0; memory contents not cleared.

Verification
REQ-030 Write 0x0f000004 wdata=0xdeadbeef wstrb=4'hf, then read 0x0f000004 -> bresp=0, rdata=0xdeadbeef, rresp=0; rvalid exactly LAT+1 cycles after ar handshake.
REQ-031 After REQ-030, write 0x0f000004 wdata=0x00aa0000 wstrb=4'b0100; read 0x0f000006 -> rdata=0xdeaabeef.
REQ-032 W presented 3 cycles before AW, bready=0 for 4 cycles after bvalid -> wready drops after W handshake, bvalid/bresp held stable, single commit.
REQ-033 Read 0x10000000 and write 0x0effffff -> rresp=2'b10, rdata=0, bresp=2'b10, memory unchanged (re-read of word 0 unchanged).
REQ-034 rst asserted during R_WAIT and during W_WAIT -> next cycle rvalid=bvalid=0, all readies 1; aborted write leaves target word unchanged.
REQ-035 Same-cycle commit to word 3 and read sampling of word 3 -> read returns old value; subsequent read returns new value.
